// File: rtl/en_strobe_gen_pkg.sv
// Shared definitions for the enable strobe generator: FSM state encoding and
// default field widths.
package en_strobe_gen_pkg;

  localparam int unsigned DefDivW = 8;
  localparam int unsigned DefCntW = 8;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/en_period_ctr.sv
// Down-counting period counter. load presets the count, enable steps it, and
// tc pulses while enabled at zero, at which point the count reloads so the
// next terminal count comes exactly reload+1 enabled cycles later.
module en_period_ctr #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] reload,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc = enable && (cnt_q == '0);

  // Next count: load wins, otherwise decrement or wrap back to the reload value.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = reload;
    end else if (enable) begin
      cnt_d = (cnt_q == '0) ? reload : cnt_q - W'(1);
    end
  end

  // Count register, cleared by asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/en_strobe_gen.sv
// Programmable active-low enable strobe generator. After start, issues one
// single-cycle en_n low strobe every div cycles (div=0 acts as 1), either for
// a finite burst (with a done pulse) or continuously until stop.
// Optional macro EN_STROBE_GEN_PAUSE_EN adds a pause input that freezes the
// period count and strobe issue while running.
module en_strobe_gen
  import en_strobe_gen_pkg::*;
#(
  parameter int unsigned DIV_W = DefDivW,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] burst,
  output logic             en_n,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] strobe_cnt
`ifdef EN_STROBE_GEN_PAUSE_EN
  ,
  input  logic             pause
`endif
);

  state_e           state_q, state_d;
  logic             en_n_q, en_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] reload_q, reload_d;
  logic [CNT_W-1:0] burst_q, burst_d;

  logic             hold;
  logic             finish;
  logic             ctr_load;
  logic             ctr_en;
  logic [DIV_W-1:0] div_m1;
  logic [DIV_W-1:0] ctr_reload;
  logic             tc;

`ifdef EN_STROBE_GEN_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // Counter reload is period-1; div of 0 behaves like 1, i.e. reload 0.
  assign div_m1     = (div == '0) ? '0 : div - DIV_W'(1);
  assign ctr_reload = (state_q == StIdle) ? div_m1 : reload_q;

  // Last strobe of a finite burst was issued on the previous edge.
  assign finish   = (burst_q != '0) && (cnt_q == burst_q);
  assign ctr_load = (state_q == StIdle) && start && !stop;
  assign ctr_en   = (state_q == StRun) && !stop && !hold && !finish;

  en_period_ctr #(
    .W(DIV_W)
  ) u_period_ctr (
    .clk   (clk),
    .rst   (rst),
    .load  (ctr_load),
    .enable(ctr_en),
    .reload(ctr_reload),
    .tc    (tc)
  );

  // Next-state and registered-output logic; stop has priority over everything.
  always_comb begin
    state_d  = state_q;
    en_n_d   = 1'b1;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    burst_d  = burst_q;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d  = StRun;
          busy_d   = 1'b1;
          cnt_d    = '0;
          reload_d = div_m1;
          burst_d  = burst;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else if (hold) begin
          // Frozen: no strobe, no completion, counter holds.
          busy_d = 1'b1;
        end else if (finish) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (tc) begin
          en_n_d = 1'b0;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset to idle values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      en_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      reload_q <= '0;
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      en_n_q   <= en_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      burst_q  <= burst_d;
    end
  end

  assign en_n       = en_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign strobe_cnt = cnt_q;

endmodule

// File: tb/tb_en_strobe_gen.sv
// Directed, table-driven bench for en_strobe_gen (default 8-bit widths).
module tb_en_strobe_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [7:0] div;
  logic [7:0] burst;
  logic       en_n;
  logic       busy;
  logic       done;
  logic [7:0] strobe_cnt;
`ifdef EN_STROBE_GEN_PAUSE_EN
  logic       pause;
`endif

  int n_checks;
  int n_fail;

  en_strobe_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .div       (div),
    .burst     (burst),
    .en_n      (en_n),
    .busy      (busy),
    .done      (done),
    .strobe_cnt(strobe_cnt)
`ifdef EN_STROBE_GEN_PAUSE_EN
    ,
    .pause     (pause)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] div;
    logic [7:0] burst;
    int         done_cyc;  // cycle in which done pulses
    int         exp_cnt;   // final strobe_cnt
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance past the next rising edge; outputs are settled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present start for exactly one edge (edge 0 of the sequence).
  task automatic do_start(input logic [7:0] d, input logic [7:0] b);
    div   = d;
    burst = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_idle(input string name, input logic [7:0] exp_cnt);
    check({name, "_en_n"}, 32'(en_n), 32'd1);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_cnt"}, 32'(strobe_cnt), 32'(exp_cnt));
  endtask

  initial begin
    int dv;
    bit exp_low;
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    div   = 8'd0;
    burst = 8'd0;
`ifdef EN_STROBE_GEN_PAUSE_EN
    pause = 1'b0;
`endif

    vecs[0] = '{8'd4, 8'd3, 13, 3};
    vecs[1] = '{8'd0, 8'd2, 3, 2};
    vecs[2] = '{8'd1, 8'd4, 5, 4};
    vecs[3] = '{8'd3, 8'd1, 4, 1};
    vecs[4] = '{8'd2, 8'd5, 11, 5};

    repeat (2) @(posedge clk);
    #2;
    check_idle("reset", 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Finite bursts from the table.
    for (int v = 0; v < 5; v++) begin
      do_start(vecs[v].div, vecs[v].burst);
      dv = (vecs[v].div == 8'd0) ? 1 : int'(vecs[v].div);
      for (int j = 1; j <= vecs[v].done_cyc; j++) begin
        tick();
        exp_low = ((j % dv) == 0) && (j < vecs[v].done_cyc);
        check($sformatf("burst%0d_en_n_c%0d", v, j), 32'(en_n), 32'(!exp_low));
        check($sformatf("burst%0d_busy_c%0d", v, j), 32'(busy), 32'(j < vecs[v].done_cyc));
        check($sformatf("burst%0d_done_c%0d", v, j), 32'(done), 32'(j == vecs[v].done_cyc));
      end
      check($sformatf("burst%0d_cnt", v), 32'(strobe_cnt), 32'(vecs[v].exp_cnt));
      tick();
      check($sformatf("burst%0d_done_clear", v), 32'(done), 32'd0);
    end

    // Continuous with div=0: en_n held low, count wraps 255 -> 0.
    do_start(8'd0, 8'd0);
    for (int j = 1; j <= 260; j++) begin
      tick();
      check($sformatf("cont_en_n_c%0d", j), 32'(en_n), 32'd0);
      check($sformatf("cont_cnt_c%0d", j), 32'(strobe_cnt), 32'(j % 256));
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle("cont_stop", 8'd4);

    // Abort: div=5, stop sampled at edge 8.
    do_start(8'd5, 8'd0);
    for (int j = 1; j <= 7; j++) begin
      tick();
      check($sformatf("abort_en_n_c%0d", j), 32'(en_n), 32'(j != 5));
      check($sformatf("abort_busy_c%0d", j), 32'(busy), 32'd1);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle("abort_e8", 8'd1);
    repeat (3) begin
      tick();
      check_idle("abort_after", 8'd1);
    end

    // Stop coinciding with the first strobe edge suppresses that strobe.
    do_start(8'd3, 8'd0);
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle("stop_on_strobe", 8'd0);

    // start+stop together in idle is a no-op.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check_idle("start_stop_idle", 8'd0);
    tick();
    check_idle("start_stop_idle2", 8'd0);

    // Start while busy with new div/burst is ignored.
    do_start(8'd2, 8'd0);
    div   = 8'd9;
    burst = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_restart_e1_en_n", 32'(en_n), 32'd1);
    tick();
    check("busy_restart_e2_en_n", 32'(en_n), 32'd0);
    tick();
    check("busy_restart_e3_busy", 32'(busy), 32'd1);
    check("busy_restart_e3_done", 32'(done), 32'd0);
    tick();
    check("busy_restart_e4_en_n", 32'(en_n), 32'd0);
    check("busy_restart_e4_cnt", 32'(strobe_cnt), 32'd2);
    tick();
    tick();
    check("busy_restart_e6_en_n", 32'(en_n), 32'd0);
    check("busy_restart_e6_cnt", 32'(strobe_cnt), 32'd3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle("busy_restart_stop", 8'd3);

    // Asynchronous reset between strobes, then a clean restart.
    do_start(8'd6, 8'd0);
    repeat (8) tick();
    check("midrst_pre_cnt", 32'(strobe_cnt), 32'd1);
    check("midrst_pre_busy", 32'(busy), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check_idle("midrst_async", 8'd0);
    #2;
    rst   = 1'b0;
    div   = 8'd2;
    burst = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("midrst_start_busy", 32'(busy), 32'd1);
    tick();
    check("midrst_e1_en_n", 32'(en_n), 32'd1);
    tick();
    check("midrst_e2_en_n", 32'(en_n), 32'd0);
    check("midrst_e2_cnt", 32'(strobe_cnt), 32'd1);
    tick();
    check("midrst_e3_done", 32'(done), 32'd1);
    check("midrst_e3_busy", 32'(busy), 32'd0);
    check("midrst_e3_en_n", 32'(en_n), 32'd1);

`ifdef EN_STROBE_GEN_PAUSE_EN
    // Pause high during cycles 2..4 delays the first strobe to cycle 7.
    do_start(8'd4, 8'd0);
    tick();
    tick();
    pause = 1'b1;
    for (int j = 3; j <= 5; j++) begin
      tick();
      check($sformatf("pause_en_n_c%0d", j), 32'(en_n), 32'd1);
      check($sformatf("pause_busy_c%0d", j), 32'(busy), 32'd1);
    end
    pause = 1'b0;
    tick();
    check("pause_e6_en_n", 32'(en_n), 32'd1);
    tick();
    check("pause_e7_en_n", 32'(en_n), 32'd0);
    check("pause_e7_cnt", 32'(strobe_cnt), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle("pause_stop", 8'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
